// File: rtl/regdest_tracker_if.sv
// -----------------------------------------------------------------------------
// regdest_tracker_if
// Purpose : groups the decode-side inputs and tracker outputs of
//           regdest_tracker into one bundle.
// Signals :
//   instruction_20_16, instruction_15_11 : rt / rd instruction fields
//   sel                                  : destination select
//   issue, retire                        : enqueue / dequeue strobes
//   rs_addr, rt_addr                     : source operands to check
//   dest                                 : combinational selected destination
//   wb_dest, wb_valid                    : oldest pending destination / non-empty
//   count, full                          : occupancy
//   hazard_rs, hazard_rt                 : operand matches a pending entry
//   overflow                             : one-cycle pulse, issue dropped when full
// Modports: master (decode / testbench side), slave (tracker side).
// -----------------------------------------------------------------------------
interface regdest_tracker_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] instruction_20_16;
  logic [ADDR_W-1:0] instruction_15_11;
  logic [1:0]        sel;
  logic              issue;
  logic              retire;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] dest;
  logic [ADDR_W-1:0] wb_dest;
  logic              wb_valid;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              hazard_rs;
  logic              hazard_rt;
  logic              overflow;

  modport master (
    output instruction_20_16, instruction_15_11, sel, issue, retire,
           rs_addr, rt_addr,
    input  dest, wb_dest, wb_valid, count, full, hazard_rs, hazard_rt,
           overflow
  );

  modport slave (
    input  instruction_20_16, instruction_15_11, sel, issue, retire,
           rs_addr, rt_addr,
    output dest, wb_dest, wb_valid, count, full, hazard_rs, hazard_rt,
           overflow
  );
endinterface

// File: rtl/regdest_tracker.sv
// -----------------------------------------------------------------------------
// regdest_tracker
// Purpose : selects the destination register of the current instruction and
//           tracks in-flight register writes in a small circular FIFO, flagging
//           read-after-write hazards on the two source operands.
// Ports   :
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : regdest_tracker_if.slave (see interface header for signals)
// Config  : define REGDEST_ZERO_FILTER_EN to drop issues whose destination is
//           register 0 instead of queueing them.
// -----------------------------------------------------------------------------
module regdest_tracker #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SP_REG = 29,
  parameter int unsigned RA_REG = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  regdest_tracker_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] r_mem;
  logic [DEPTH-1:0]             r_valid;
  logic [PTR_W-1:0]             r_wr_ptr;
  logic [PTR_W-1:0]             r_rd_ptr;
  logic [CNT_W-1:0]             r_count;
  logic                         r_overflow;

  logic [ADDR_W-1:0] w_dest;
  logic              w_empty;
  logic              w_full;
  logic              w_enq_req;
  logic              w_do_enq;
  logic              w_do_deq;
  logic              w_haz_rs;
  logic              w_haz_rt;

  // Destination select; every sel value maps to a defined register.
  always_comb begin
    w_dest = bus.instruction_20_16;
    case (bus.sel)
      2'b00:   w_dest = bus.instruction_20_16;
      2'b01:   w_dest = bus.instruction_15_11;
      2'b10:   w_dest = ADDR_W'(SP_REG);
      default: w_dest = ADDR_W'(RA_REG);
    endcase
  end

  // Occupancy comes only from the count, never from pointer comparison.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef REGDEST_ZERO_FILTER_EN
  assign w_enq_req = bus.issue && (w_dest != '0);
`else
  assign w_enq_req = bus.issue;
`endif

  // A same-edge retire frees the head slot, so a full queue can still accept.
  assign w_do_deq = bus.retire && !w_empty;
  assign w_do_enq = w_enq_req && (!w_full || w_do_deq);

  // Operand match against every live entry; register 0 never conflicts.
  always_comb begin
    w_haz_rs = 1'b0;
    w_haz_rt = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_valid[i] && (r_mem[i] == bus.rs_addr) && (bus.rs_addr != '0))
        w_haz_rs = 1'b1;
      if (r_valid[i] && (r_mem[i] == bus.rt_addr) && (bus.rt_addr != '0))
        w_haz_rt = 1'b1;
    end
  end

  // FIFO state; on a full swap both pointers hit the same slot and the
  // enqueue's valid set (written last) takes precedence over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem      <= '0;
      r_valid    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_enq_req && w_full && !w_do_deq;
      if (w_do_deq) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= PTR_W'(r_rd_ptr + 1'b1);
      end
      if (w_do_enq) begin
        r_mem[r_wr_ptr]   <= w_dest;
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= PTR_W'(r_wr_ptr + 1'b1);
      end
      case ({w_do_enq, w_do_deq})
        2'b10:   r_count <= CNT_W'(r_count + 1'b1);
        2'b01:   r_count <= CNT_W'(r_count - 1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.dest      = w_dest;
  assign bus.wb_dest   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.wb_valid  = !w_empty;
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.hazard_rs = w_haz_rs;
  assign bus.hazard_rt = w_haz_rt;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_regdest_tracker.sv
// -----------------------------------------------------------------------------
// tb_regdest_tracker
// Purpose : self-checking bench for regdest_tracker (DEPTH=4, ADDR_W=5).
//           A queue-based model tracks pending destinations; a compare process
//           checks every DUT output against it on each falling edge, and
//           directed scenarios pin the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_regdest_tracker;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 4;

  logic clk;
  logic reset_n;

  regdest_tracker_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  regdest_tracker #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .SP_REG(29),
    .RA_REG(31)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  q[$];
  bit  m_ovf = 1'b0;
  int  m_d;
  bit  m_req;
  bit  m_empty;
  bit  m_full;

  function automatic int sel_dest(input int s, input int rt, input int rd);
    case (s)
      0:       return rt;
      1:       return rd;
      2:       return 29;
      default: return 31;
    endcase
  endfunction

  function automatic bit pending(input int a);
    if (a == 0) return 1'b0;
    foreach (q[i]) if (q[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      m_d     = sel_dest(int'(bus.sel), int'(bus.instruction_20_16), int'(bus.instruction_15_11));
      m_req   = bus.issue;
`ifdef REGDEST_ZERO_FILTER_EN
      if (m_d == 0) m_req = 1'b0;
`endif
      m_empty = (q.size() == 0);
      m_full  = (q.size() == int'(DEPTH));
      m_ovf   = 1'b0;
      if (bus.retire && !m_empty) void'(q.pop_front());
      if (m_req) begin
        if (!m_full || (bus.retire && !m_empty)) q.push_back(m_d);
        else m_ovf = 1'b1;
      end
    end
  end

  // Continuous comparison away from the rising edge.
  always @(negedge clk) begin
    chk("dest", int'(bus.dest),
        sel_dest(int'(bus.sel), int'(bus.instruction_20_16), int'(bus.instruction_15_11)));
    chk("wb_dest", int'(bus.wb_dest), (q.size() > 0) ? q[0] : 0);
    chk("wb_valid", int'(bus.wb_valid), int'(q.size() > 0));
    chk("count", int'(bus.count), q.size());
    chk("full", int'(bus.full), int'(q.size() == int'(DEPTH)));
    chk("hazard_rs", int'(bus.hazard_rs), int'(pending(int'(bus.rs_addr))));
    chk("hazard_rt", int'(bus.hazard_rt), int'(pending(int'(bus.rt_addr))));
    chk("overflow", int'(bus.overflow), int'(m_ovf));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.instruction_20_16 = '0;
    bus.instruction_15_11 = '0;
    bus.sel               = 2'b00;
    bus.issue             = 1'b0;
    bus.retire            = 1'b0;
    bus.rs_addr           = '0;
    bus.rt_addr           = '0;
  endtask

  function automatic logic [ADDR_W-1:0] rnd_src();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 8) return ADDR_W'(r);
    return (r == 8) ? ADDR_W'(29) : ADDR_W'(31);
  endfunction

  int heads[6];

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("rst_count", int'(bus.count), 0);
    chk("rst_wb_valid", int'(bus.wb_valid), 0);
    chk("rst_overflow", int'(bus.overflow), 0);

    // Single issue then hazard next cycle.
    bus.sel = 2'b01; bus.instruction_15_11 = 5'd8; bus.issue = 1'b1;
    tick();
    bus.issue = 1'b0; bus.rs_addr = 5'd8;
    #1;
    chk("t1_hazard_rs", int'(bus.hazard_rs), 1);
    chk("t1_count", int'(bus.count), 1);
    chk("t1_wb_dest", int'(bus.wb_dest), 8);
    chk("t1_wb_valid", int'(bus.wb_valid), 1);
    bus.retire = 1'b1;
    tick();
    bus.retire = 1'b0;

    // Fill to full, then overflow on a lone issue.
    bus.sel = 2'b00; bus.issue = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.instruction_20_16 = ADDR_W'(3 + 2 * k);
      tick();
    end
    chk("t2_full", int'(bus.full), 1);
    bus.instruction_20_16 = 5'd11;
    tick();
    bus.issue = 1'b0;
    chk("t2_overflow", int'(bus.overflow), 1);
    chk("t2_count", int'(bus.count), 4);
    tick();
    chk("t2_overflow_clr", int'(bus.overflow), 0);
    bus.retire = 1'b1;
    tick();
    bus.retire = 1'b0;
    chk("t2_wb_dest", int'(bus.wb_dest), 5);

    // Refill, then six issue+retire swaps while full.
    bus.instruction_20_16 = 5'd13; bus.issue = 1'b1;
    tick();
    heads = '{7, 9, 13, 20, 21, 22};
    bus.retire = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.instruction_20_16 = ADDR_W'(20 + k);
      tick();
      chk("t3_count", int'(bus.count), 4);
      chk("t3_wb_dest", int'(bus.wb_dest), heads[k]);
    end
    chk("t3_no_ovf", int'(bus.overflow), 0);
    bus.issue = 1'b0;
    repeat (4) tick();
    bus.retire = 1'b0;
    chk("t3_drained", int'(bus.count), 0);

    // Fixed SP / RA destinations.
    bus.issue = 1'b1; bus.sel = 2'b10;
    tick();
    bus.sel = 2'b11;
    tick();
    bus.issue = 1'b0; bus.rt_addr = 5'd31; bus.rs_addr = 5'd0;
    #1;
    chk("t4_hazard_rt", int'(bus.hazard_rt), 1);
    chk("t4_hazard_rs0", int'(bus.hazard_rs), 0);
    chk("t4_wb_dest", int'(bus.wb_dest), 29);

    // Asynchronous reset with three pending entries.
    bus.sel = 2'b01; bus.instruction_15_11 = 5'd8; bus.issue = 1'b1;
    tick();
    bus.issue = 1'b0; bus.rs_addr = 5'd29;
    chk("t5_pre_count", int'(bus.count), 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_count", int'(bus.count), 0);
    chk("t5_rst_wb_valid", int'(bus.wb_valid), 0);
    chk("t5_rst_wb_dest", int'(bus.wb_dest), 0);
    chk("t5_rst_haz_rs", int'(bus.hazard_rs), 0);
    chk("t5_rst_haz_rt", int'(bus.hazard_rt), 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.retire = 1'b1;
    tick();
    bus.retire = 1'b0;
    chk("t5_retire_empty", int'(bus.count), 0);
    chk("t5_retire_empty_v", int'(bus.wb_valid), 0);

    // Destination register 0.
    bus.sel = 2'b00; bus.instruction_20_16 = 5'd0; bus.issue = 1'b1;
    tick();
    bus.issue = 1'b0; bus.rs_addr = 5'd0;
    #1;
`ifdef REGDEST_ZERO_FILTER_EN
    chk("t6_zero_count", int'(bus.count), 0);
`else
    chk("t6_zero_count", int'(bus.count), 1);
`endif
    chk("t6_zero_haz", int'(bus.hazard_rs), 0);

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 3000; n++) begin
      bus.sel               = 2'($urandom_range(0, 3));
      bus.instruction_20_16 = ADDR_W'($urandom_range(0, 7));
      bus.instruction_15_11 = ADDR_W'($urandom_range(0, 7));
      bus.issue             = ($urandom_range(0, 99) < 55);
      bus.retire            = ($urandom_range(0, 99) < 45);
      bus.rs_addr           = rnd_src();
      bus.rt_addr           = rnd_src();
      if ($urandom_range(0, 249) == 0) begin
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
      end
      tick();
    end

    idle();
    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/regdest_tracker.md
REGDEST_TRACKER -- requirements
Module: regdest_tracker

Interface
REQ-001 Parameter ADDR_W, default 5, register address width.
REQ-002 Parameter DEPTH, default 4 (power of two, >=2), maximum in-flight pending writes.
REQ-003 Parameter SP_REG, default 29, destination for sel=2'b10.
REQ-004 Parameter RA_REG, default 31, destination for sel=2'b11.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 instruction_20_16  in  ADDR_W  rt field.
REQ-008 instruction_15_11  in  ADDR_W  rd field.
REQ-009 sel  in  2  destination select.
REQ-010 issue  in  1  enqueue current dest as a pending write.
REQ-011 retire  in  1  dequeue oldest pending write (write-back done).
REQ-012 rs_addr, rt_addr  in  ADDR_W each  source operands to check.
REQ-013 dest  out  ADDR_W  combinational selected destination.
REQ-014 wb_dest  out  ADDR_W  oldest pending destination; 0 when empty.
REQ-015 wb_valid  out  1  queue non-empty.
REQ-016 count  out  $clog2(DEPTH)+1  number of pending entries.
REQ-017 full  out  1  count==DEPTH.
REQ-018 hazard_rs, hazard_rt  out  1 each  operand matches a pending entry.
REQ-019 overflow  out  1  one-cycle pulse: issue dropped because full.

Function
REQ-020 dest SHALL be: sel 00 -> instruction_20_16; 01 -> instruction_15_11; 10 -> SP_REG; 11 -> RA_REG; no latch, no X for any sel.
REQ-021 Entries SHALL be held in a circular FIFO of DEPTH entries with wrapping read/write pointers; dest is captured at the edge where issue=1.
REQ-022 issue=1, retire=0, not full: enqueue, count+1.
REQ-023 issue=0, retire=1, not empty: dequeue, count-1.
REQ-024 issue=1, retire=1, not empty: enqueue and dequeue in the same edge, count unchanged (including when full).
REQ-025 issue=1, retire=1, empty: enqueue only, count becomes 1; retire ignored.
REQ-026 issue=1, retire=0, full: issue dropped, state unchanged, overflow=1 for the following cycle only.
REQ-027 retire=1 when empty SHALL be ignored with no state change.
REQ-028 hazard_rs SHALL be 1 iff rs_addr!=0 and equals the dest of any valid entry; hazard_rt likewise; combinational from registered state, so an entry issued this cycle is visible from the next cycle.
REQ-029 An entry retiring this cycle SHALL still flag hazard in this cycle.
REQ-030 wb_dest/wb_valid SHALL reflect the head entry with zero-cycle latency from registered state.
REQ-031 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; count is the sole full/empty source.

Reset
REQ-032 reset_n=0 SHALL immediately clear pointers, count, all entry valid bits and overflow, regardless of clk.
REQ-033 Outputs during/after reset: wb_dest=0, wb_valid=0, count=0, full=0, hazard_rs=hazard_rt=0, overflow=0; dest stays combinational.
REQ-034 Reset asserted mid-operation SHALL discard all pending entries; no partial state survives.

Configuration
REQ-035 Macro REGDEST_ZERO_FILTER_EN: when defined, issue with dest==0 SHALL NOT enqueue (no count change, no overflow even when full, retire in same cycle still honoured).
REQ-036 Without REGDEST_ZERO_FILTER_EN, dest==0 SHALL enqueue normally and occupy a slot, but never raise hazard (REQ-028).

Verification
REQ-037 Reset, then sel=01, rd=8, issue 1 cycle; rs_addr=8 -> next cycle hazard_rs=1, count=1, wb_dest=8, wb_valid=1.
REQ-038 Issue dests 3,5,7,9 (DEPTH=4) -> full=1; issue 11 alone -> overflow pulse 1 cycle, count=4; retire -> wb_dest becomes 5.
REQ-039 With full, issue+retire same cycle 6 times -> count stays 4, pointers wrap, wb_dest order matches issue order.
REQ-040 sel=10 and 11 with issue -> queued dests 29 and 31; rt_addr=31 -> hazard_rt=1; rs_addr=0 -> hazard_rs=0 always.
REQ-041 Three entries pending, drop reset_n between edges -> count=0, wb_valid=0, hazards 0 immediately; retire on empty after release -> no change.
REQ-042 issue with sel=00, rt=0: with REGDEST_ZERO_FILTER_EN count stays 0; without it count becomes 1 and hazard_rs for rs_addr=0 stays 0.
